or1200_fetch_resp: RTL and testbench

Instruction-fetch responder: the slave end of the `icpu_*` fetch interface that `or1200_genpc` drives. It accepts the fetch address and strobe, enforces a configurable wait-state latency, and returns a word from an internal preloadable instruction store. It signals ack, retry or error, echoes the served address and tag, and aborts cleanly when genpc drops the strobe or redirects during refetch or exception.

---
 rtl/or1200_fetch_pkg.sv | 14 +
 rtl/or1200_fetch_rom.sv | 28 ++
 rtl/or1200_fetch_resp.sv | 175 +++++++++++++++++
 tb/tb_or1200_fetch_resp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/or1200_fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package or1200_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        RESP
    } fetch_state_t;

    localparam logic [3:0] FETCH_SEL_ALL = 4'hF;
    localparam int unsigned FETCH_TAG_W  = 4;

endpackage

// File: rtl/or1200_fetch_rom.sv
// Single-clock instruction store: one write port, one synchronous read port, no reset.
module or1200_fetch_rom #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] wadr_i,
    input  logic [31:0]           wdat_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] radr_i,
    output logic [31:0]           rdat_o
);

    logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] rdat_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wadr_i] <= wdat_i;
        end
        if (re_i) begin
            rdat_q <= mem_q[radr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/or1200_fetch_resp.sv
// Slave end of the icpu fetch interface: wait-state latency, store read,
// ack/err/rty response and abort on strobe drop, redirect or loader collision.
module or1200_fetch_resp
    import or1200_fetch_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            icpu_adr_i,
    input  logic                   icpu_cycstb_i,
    input  logic [3:0]             icpu_sel_i,
    input  logic [FETCH_TAG_W-1:0] icpu_tag_i,
    input  logic                   ld_we,
    input  logic [DEPTH_LOG2-1:0]  ld_adr,
    input  logic [31:0]            ld_dat,
    output logic [31:0]            icpu_dat_o,
    output logic                   icpu_ack_o,
    output logic                   icpu_rty_o,
    output logic                   icpu_err_o,
    output logic [31:0]            icpu_adr_o,
    output logic [FETCH_TAG_W-1:0] icpu_tag_o
);

    fetch_state_t           state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [31:0]            req_adr_q, req_adr_d;
    logic [FETCH_TAG_W-1:0] req_tag_q, req_tag_d;
    logic [DEPTH_LOG2-1:0]  req_idx_q, req_idx_d;
    logic                   req_err_q, req_err_d;
    logic [31:0]            dat_q, dat_d;
    logic [31:0]            adr_q, adr_d;
    logic [FETCH_TAG_W-1:0] tag_q, tag_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   rty_q, rty_d;

    logic [31:0] offset;
    logic        req_bad;
    logic        collide;
    logic        stale;
    logic        rd_en;
    logic [31:0] rom_dat;

    // Unsigned wrap makes addresses below BASE_ADDR land out of range.
    assign offset  = icpu_adr_i - BASE_ADDR;
    assign req_bad = (icpu_adr_i[1:0] != 2'b00) || (icpu_sel_i != FETCH_SEL_ALL)
                     || ((offset >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign collide = icpu_cycstb_i && ld_we;
    assign stale   = !icpu_cycstb_i || (icpu_adr_i != req_adr_q);

    or1200_fetch_rom #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_rom (
        .clk    (clk),
        .we_i   (ld_we),
        .wadr_i (ld_adr),
        .wdat_i (ld_dat),
        .re_i   (rd_en),
        .radr_i (req_idx_q),
        .rdat_o (rom_dat)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_adr_d = req_adr_q;
        req_tag_d = req_tag_q;
        req_idx_d = req_idx_q;
        req_err_d = req_err_q;
        dat_d     = dat_q;
        adr_d     = adr_q;
        tag_d     = tag_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rty_d     = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (collide) begin
                    rty_d = 1'b1;
                end else if (icpu_cycstb_i) begin
                    req_adr_d = icpu_adr_i;
                    req_tag_d = icpu_tag_i;
                    req_idx_d = offset[DEPTH_LOG2+1:2];
                    req_err_d = req_bad;
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WAIT: begin
                if (collide) begin
                    rty_d   = 1'b1;
                    state_d = IDLE;
                end else if (stale) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READ: begin
                if (collide) begin
                    rty_d   = 1'b1;
                    state_d = IDLE;
                end else if (stale) begin
                    state_d = IDLE;
                end else begin
                    rd_en   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (req_err_q) begin
                    err_d = 1'b1;
                    dat_d = '0;
                end else begin
                    ack_d = 1'b1;
                    dat_d = rom_dat;
                end
                adr_d   = req_adr_q;
                tag_d   = req_tag_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_adr_q <= '0;
            req_tag_q <= '0;
            req_idx_q <= '0;
            req_err_q <= 1'b0;
            dat_q     <= '0;
            adr_q     <= '0;
            tag_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rty_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_adr_q <= req_adr_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            req_err_q <= req_err_d;
            dat_q     <= dat_d;
            adr_q     <= adr_d;
            tag_q     <= tag_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rty_q     <= rty_d;
        end
    end

    assign icpu_dat_o = dat_q;
    assign icpu_ack_o = ack_q;
    assign icpu_err_o = err_q;
    assign icpu_rty_o = rty_q;
    assign icpu_adr_o = adr_q;
    assign icpu_tag_o = tag_q;

endmodule

// File: tb/tb_or1200_fetch_resp.sv
// Directed bench for or1200_fetch_resp with a timestamp-based reference model.
module tb_or1200_fetch_resp;

    localparam int unsigned DL   = 10;
    localparam int unsigned WC   = 1;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic [31:0]   adr;
    logic          cycstb;
    logic [3:0]    sel;
    logic [3:0]    tag;
    logic          ld_we;
    logic [DL-1:0] ld_adr;
    logic [31:0]   ld_dat;
    logic [31:0]   dat_o;
    logic          ack_o, rty_o, err_o;
    logic [31:0]   adr_o;
    logic [3:0]    tag_o;

    int total = 0;
    int bad   = 0;

    or1200_fetch_resp #(
        .DEPTH_LOG2  (DL),
        .WAIT_CYCLES (WC),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .icpu_adr_i    (adr),
        .icpu_cycstb_i (cycstb),
        .icpu_sel_i    (sel),
        .icpu_tag_i    (tag),
        .ld_we         (ld_we),
        .ld_adr        (ld_adr),
        .ld_dat        (ld_dat),
        .icpu_dat_o    (dat_o),
        .icpu_ack_o    (ack_o),
        .icpu_rty_o    (rty_o),
        .icpu_err_o    (err_o),
        .icpu_adr_o    (adr_o),
        .icpu_tag_o    (tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a request is a timestamp; the response edge is accept+WC+2
    // (accept+1 for a bad request) unless an abort rule fires first.
    logic [31:0] mem [0:(1<<DL)-1];
    logic        mvalid = 1'b0;
    logic        busy = 1'b0;
    int          edge_n = 0;
    int          acc_n = 0;
    logic [31:0] m_adr, m_rd, m_off;
    logic [3:0]  m_tag;
    logic        m_err;
    logic [31:0] e_dat, e_adr;
    logic [3:0]  e_tag;
    logic        e_ack, e_err, e_rty;

    always @(posedge clk) begin
        edge_n++;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_rty = 1'b0;
        if (!rst) begin
            mvalid = 1'b1;
            busy   = 1'b0;
            e_dat  = 32'd0;
            e_adr  = 32'd0;
            e_tag  = 4'd0;
        end else if (busy) begin
            if (m_err) begin
                e_err = 1'b1;
                e_dat = 32'd0;
                e_adr = m_adr;
                e_tag = m_tag;
                busy  = 1'b0;
            end else if (edge_n < acc_n + int'(WC) + 2) begin
                if (cycstb && ld_we) begin
                    e_rty = 1'b1;
                    busy  = 1'b0;
                end else if (!cycstb || adr != m_adr) begin
                    busy = 1'b0;
                end else if (edge_n == acc_n + int'(WC) + 1) begin
                    m_rd = mem[(m_adr - BASE) >> 2];
                end
            end else begin
                e_ack = 1'b1;
                e_dat = m_rd;
                e_adr = m_adr;
                e_tag = m_tag;
                busy  = 1'b0;
            end
        end else if (cycstb && ld_we) begin
            e_rty = 1'b1;
        end else if (cycstb) begin
            busy  = 1'b1;
            acc_n = edge_n;
            m_adr = adr;
            m_tag = tag;
            m_off = adr - BASE;
            m_err = (adr % 4 != 0) || (sel != 4'hF) || ((m_off / 4) >= (1 << DL));
        end
        if (ld_we) mem[ld_adr] = ld_dat;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_ack", {31'd0, ack_o}, {31'd0, e_ack});
            chk("m_err", {31'd0, err_o}, {31'd0, e_err});
            chk("m_rty", {31'd0, rty_o}, {31'd0, e_rty});
            chk("m_dat", dat_o, e_dat);
            chk("m_adr", adr_o, e_adr);
            chk("m_tag", {28'd0, tag_o}, {28'd0, e_tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [31:0] a, input logic [3:0] tg);
        cycstb = 1'b1;
        adr    = a;
        tag    = tg;
        tick();
    endtask

    task automatic load(input logic [DL-1:0] a, input logic [31:0] d);
        ld_we  = 1'b1;
        ld_adr = a;
        ld_dat = d;
        tick();
        ld_we  = 1'b0;
    endtask

    task automatic chk_ack(input string nm, input logic [31:0] d, input logic [31:0] a,
                           input logic [3:0] tg);
        chk({nm, "_ack"}, {31'd0, ack_o}, 32'd1);
        chk({nm, "_dat"}, dat_o, d);
        chk({nm, "_adr"}, adr_o, a);
        chk({nm, "_tag"}, {28'd0, tag_o}, {28'd0, tg});
    endtask

    task automatic chk_errp(input string nm, input logic [31:0] a);
        chk({nm, "_err"}, {31'd0, err_o}, 32'd1);
        chk({nm, "_ack"}, {31'd0, ack_o}, 32'd0);
        chk({nm, "_dat"}, dat_o, 32'd0);
        chk({nm, "_adr"}, adr_o, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cycstb = 1'b0; adr = '0; sel = 4'hF; tag = '0;
        ld_we = 1'b0; ld_adr = '0; ld_dat = '0;
        repeat (3) tick();
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        rst = 1'b1;
        load(10'd5,  32'h1500_0000);
        load(10'd16, 32'hA0A0_0016);
        load(10'd8,  32'h0800_0008);
        tick();

        // normal fetch: ack three cycles after accept
        req(32'h14, 4'h3);
        tick(); tick();
        chk("lat_early", {31'd0, ack_o}, 32'd0);
        tick();
        chk_ack("fetch", 32'h1500_0000, 32'h14, 4'h3);
        cycstb = 1'b0;
        tick();
        chk("ack_one_cycle", {31'd0, ack_o}, 32'd0);

        req(32'h16, 4'hA);
        tick();
        chk_errp("misalign", 32'h16);
        cycstb = 1'b0; tick();

        sel = 4'h7;
        req(32'h14, 4'hB);
        tick();
        chk_errp("badsel", 32'h14);
        sel = 4'hF; cycstb = 1'b0; tick();

        req(32'h1000, 4'hC);
        tick();
        chk_errp("range", 32'h1000);
        chk("range_tag", {28'd0, tag_o}, 32'hC);
        cycstb = 1'b0; tick();

        // redirect in WAIT: abort, re-accept, serve word 16
        req(32'h20, 4'h5);
        adr = 32'h40;
        tick(); tick();
        tick(); tick();
        chk("redir_none", {31'd0, ack_o}, 32'd0);
        tick();
        chk_ack("redir", 32'hA0A0_0016, 32'h40, 4'h5);
        cycstb = 1'b0; tick();

        // strobe dropped in READ
        req(32'h20, 4'h6);
        tick();
        cycstb = 1'b0;
        repeat (4) begin
            tick();
            chk("drop_quiet", {29'd0, ack_o, err_o, rty_o}, 32'd0);
        end

        // loader collision in WAIT: retry, then new data served
        req(32'h20, 4'h7);
        ld_we = 1'b1; ld_adr = 10'd8; ld_dat = 32'hDEAD_0008;
        tick();
        chk("retry_rty", {31'd0, rty_o}, 32'd1);
        chk("retry_ack", {31'd0, ack_o}, 32'd0);
        ld_we = 1'b0;
        tick();
        chk("retry_one", {31'd0, rty_o}, 32'd0);
        repeat (3) tick();
        chk_ack("refetch", 32'hDEAD_0008, 32'h20, 4'h7);
        cycstb = 1'b0; tick();

        // reset in WAIT clears outputs; request accepted once reset releases
        req(32'h14, 4'h9);
        rst = 1'b0;
        tick();
        chk("mid_rst", {dat_o[31:3], ack_o, err_o, rty_o}, 32'd0);
        chk("mid_rst_adr", adr_o, 32'd0);
        rst = 1'b1;
        tick();
        repeat (3) tick();
        chk_ack("post_rst", 32'h1500_0000, 32'h14, 4'h9);
        cycstb = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
